// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 timing and width helpers for the VGA scan logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_pkg;

  // Segment of one scan axis; the order is the order the scan walks through them.
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } seg_state_e;

  // 640x480@60 from a 50 MHz clock (25 MHz pixel rate).
  localparam int unsigned DefPixelDiv   = 2;
  localparam int unsigned DefHActive    = 640;
  localparam int unsigned DefHFront     = 16;
  localparam int unsigned DefHSync      = 96;
  localparam int unsigned DefHBack      = 48;
  localparam int unsigned DefVActive    = 480;
  localparam int unsigned DefVFront     = 10;
  localparam int unsigned DefVSync      = 2;
  localparam int unsigned DefVBack      = 33;
  localparam int unsigned DefHCountSize = 11;
  localparam int unsigned DefVCountSize = 10;

  // Bits needed for a counter running 0..n-1; never less than one bit.
  function automatic int unsigned clog2w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_controller_if.sv
// Scan-timing bundle between the timing controller (master) and the colour path (slave).
// Latency: n/a (wiring only).
// Backpressure: none; enable is the only input and freezes the whole scan when low.
interface vga_timing_controller_if #(
  parameter int unsigned HCountSize = 11,
  parameter int unsigned VCountSize = 10
);
  logic                  enable;
  logic                  pixel_tick;
  logic                  hsync;
  logic                  vsync;
  logic                  active;
  logic [HCountSize-1:0] hpos;
  logic [VCountSize-1:0] vpos;
  logic                  line_start;
  logic                  frame_start;

  modport master (
    input  enable,
    output pixel_tick, hsync, vsync, active, hpos, vpos, line_start, frame_start
  );

  modport slave (
    output enable,
    input  pixel_tick, hsync, vsync, active, hpos, vpos, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_fsm.sv
// One scan axis: walks ACTIVE->FRONT->SYNC->BACK, tracking segment count and absolute position.
// Latency: state/pos move on the edge where advance=1; state_nxt exposes the coming state.
// Backpressure: none; the axis holds whenever advance=0.
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int unsigned ActiveLen = DefHActive,
  parameter int unsigned FrontLen  = DefHFront,
  parameter int unsigned SyncLen   = DefHSync,
  parameter int unsigned BackLen   = DefHBack,
  parameter int unsigned CountSize = DefHCountSize
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 advance,
  output seg_state_e           state,
  output seg_state_e           state_nxt,
  output logic [CountSize-1:0] pos,
  output logic                 wrap
);

  localparam int unsigned MaxAF  = (ActiveLen > FrontLen) ? ActiveLen : FrontLen;
  localparam int unsigned MaxSB  = (SyncLen > BackLen) ? SyncLen : BackLen;
  localparam int unsigned MaxLen = (MaxAF > MaxSB) ? MaxAF : MaxSB;
  localparam int unsigned SegW   = clog2w(MaxLen);

  localparam logic [SegW-1:0] ActiveLast = SegW'(ActiveLen - 1);
  localparam logic [SegW-1:0] FrontLast  = SegW'(FrontLen - 1);
  localparam logic [SegW-1:0] SyncLast   = SegW'(SyncLen - 1);
  localparam logic [SegW-1:0] BackLast   = SegW'(BackLen - 1);

  seg_state_e           state_q, state_d;
  logic [SegW-1:0]      seg_q, seg_d;
  logic [CountSize-1:0] pos_q, pos_d;
  logic                 seg_last;

  // Last position of the current segment.
  always_comb begin
    seg_last = 1'b0;
    case (state_q)
      ACTIVE:  seg_last = (seg_q == ActiveLast);
      FRONT:   seg_last = (seg_q == FrontLast);
      SYNC:    seg_last = (seg_q == SyncLast);
      BACK:    seg_last = (seg_q == BackLast);
      default: seg_last = 1'b0;
    endcase
  end

  assign wrap = (state_q == BACK) && seg_last;

  // Next segment/position; position wraps exactly when the BACK segment ends.
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    pos_d   = pos_q;
    if (advance) begin
      pos_d = wrap ? '0 : pos_q + 1'b1;
      if (seg_last) begin
        seg_d = '0;
        case (state_q)
          ACTIVE:  state_d = FRONT;
          FRONT:   state_d = SYNC;
          SYNC:    state_d = BACK;
          default: state_d = ACTIVE;
        endcase
      end else begin
        seg_d = seg_q + 1'b1;
      end
    end
  end

  // Axis state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACTIVE;
      seg_q   <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      pos_q   <= pos_d;
    end
  end

  assign state     = state_q;
  assign state_nxt = state_d;
  assign pos       = pos_q;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA scan sequencer: pixel prescaler, h/v segment FSMs, registered sync/active/strobe outputs.
// Latency: outputs change on the pixel_tick edge, aligned with hpos/vpos (zero skew).
// Backpressure: enable=0 freezes prescaler, position and levels; strobes read 0.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int unsigned PixelDiv   = DefPixelDiv,
  parameter int unsigned HActive    = DefHActive,
  parameter int unsigned HFront     = DefHFront,
  parameter int unsigned HSync      = DefHSync,
  parameter int unsigned HBack      = DefHBack,
  parameter int unsigned VActive    = DefVActive,
  parameter int unsigned VFront     = DefVFront,
  parameter int unsigned VSync      = DefVSync,
  parameter int unsigned VBack      = DefVBack,
  parameter int unsigned HSyncPol   = 0,
  parameter int unsigned VSyncPol   = 0,
  parameter int unsigned HCountSize = DefHCountSize,
  parameter int unsigned VCountSize = DefVCountSize
) (
  input logic                     clock,
  input logic                     reset,
  vga_timing_controller_if.master vga
);

  localparam int unsigned HTotal  = HActive + HFront + HSync + HBack;
  localparam int unsigned VTotal  = VActive + VFront + VSync + VBack;
  localparam int unsigned PreW    = clog2w(PixelDiv);
  localparam logic [PreW-1:0] PreLast = PreW'(PixelDiv - 1);
  localparam logic HSyncOn = (HSyncPol != 0);
  localparam logic VSyncOn = (VSyncPol != 0);

  // Zero-length segments would make a state unreachable; refuse them at elaboration.
  if (PixelDiv < 1 || HActive < 1 || HFront < 1 || HSync < 1 || HBack < 1 ||
      VActive < 1 || VFront < 1 || VSync < 1 || VBack < 1) begin : g_bad_timing
    $error("vga_timing_controller: every timing parameter must be >= 1");
  end
  if (((HTotal - 1) >> HCountSize) != 0 || ((VTotal - 1) >> VCountSize) != 0) begin : g_bad_width
    $error("vga_timing_controller: position width too small for the line/frame total");
  end

  logic [PreW-1:0] presc_q, presc_d;
  logic            pixel_tick;
  seg_state_e      h_state_unused, v_state_unused;
  seg_state_e      h_state_nxt, v_state_nxt;
  logic            h_wrap, v_wrap, v_adv;
  logic            active_q, hsync_q, vsync_q, line_start_q, frame_start_q;

  assign pixel_tick = vga.enable && (presc_q == PreLast);
  assign v_adv      = pixel_tick && h_wrap;

  // Prescaler counts only while enabled and restarts on every pixel tick.
  always_comb begin
    presc_d = presc_q;
    if (vga.enable) begin
      presc_d = pixel_tick ? '0 : presc_q + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clock) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  vga_axis_fsm #(
    .ActiveLen (HActive),
    .FrontLen  (HFront),
    .SyncLen   (HSync),
    .BackLen   (HBack),
    .CountSize (HCountSize)
  ) u_h_axis (
    .clock     (clock),
    .reset     (reset),
    .advance   (pixel_tick),
    .state     (h_state_unused),
    .state_nxt (h_state_nxt),
    .pos       (vga.hpos),
    .wrap      (h_wrap)
  );

  vga_axis_fsm #(
    .ActiveLen (VActive),
    .FrontLen  (VFront),
    .SyncLen   (VSync),
    .BackLen   (VBack),
    .CountSize (VCountSize)
  ) u_v_axis (
    .clock     (clock),
    .reset     (reset),
    .advance   (v_adv),
    .state     (v_state_unused),
    .state_nxt (v_state_nxt),
    .pos       (vga.vpos),
    .wrap      (v_wrap)
  );

  // Outputs registered from the FSMs' next state so they land on the same edge as hpos/vpos.
  always_ff @(posedge clock) begin
    if (reset) begin
      active_q      <= 1'b1;
      hsync_q       <= ~HSyncOn;
      vsync_q       <= ~VSyncOn;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      active_q      <= (h_state_nxt == ACTIVE) && (v_state_nxt == ACTIVE);
      hsync_q       <= (h_state_nxt == SYNC) ? HSyncOn : ~HSyncOn;
      vsync_q       <= (v_state_nxt == SYNC) ? VSyncOn : ~VSyncOn;
      line_start_q  <= pixel_tick && h_wrap;
      frame_start_q <= pixel_tick && h_wrap && v_wrap;
    end
  end

  assign vga.pixel_tick  = pixel_tick;
  assign vga.active      = active_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: small-timing instances (both sync polarities) and a default 640x480 instance.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: enable stall exercised on the default instance.
module tb_vga_timing_controller;

  logic clk;
  logic rst_d;
  logic rst_s;
  int   n_checks = 0;
  int   n_err    = 0;
  int   ns;
  int   c;
  bit   last_en;

  vga_timing_controller_if #(.HCountSize(11), .VCountSize(10)) vga_d ();
  vga_timing_controller_if #(.HCountSize(4),  .VCountSize(4))  vga_s ();
  vga_timing_controller_if #(.HCountSize(4),  .VCountSize(4))  vga_p ();

  vga_timing_controller u_def (
    .clock (clk),
    .reset (rst_d),
    .vga   (vga_d)
  );

  vga_timing_controller #(
    .PixelDiv(1), .HActive(4), .HFront(1), .HSync(2), .HBack(1),
    .VActive(3), .VFront(1), .VSync(1), .VBack(1),
    .HSyncPol(0), .VSyncPol(0), .HCountSize(4), .VCountSize(4)
  ) u_sml (
    .clock (clk),
    .reset (rst_s),
    .vga   (vga_s)
  );

  vga_timing_controller #(
    .PixelDiv(1), .HActive(4), .HFront(1), .HSync(2), .HBack(1),
    .VActive(3), .VFront(1), .VSync(1), .VBack(1),
    .HSyncPol(1), .VSyncPol(1), .HCountSize(4), .VCountSize(4)
  ) u_pol (
    .clock (clk),
    .reset (rst_s),
    .vga   (vga_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Small timing: 8 pixels/line (sync at 5,6), 6 lines/frame (sync at line 4), one pixel per clock.
  task automatic chk_small(input int n);
    int h, v;
    bit hs, vs, act, ls, fs;
    h   = n % 8;
    v   = (n / 8) % 6;
    hs  = (h == 5 || h == 6);
    vs  = (v == 4);
    act = (h < 4) && (v < 3);
    ls  = (n > 0) && (h == 0);
    fs  = ls && (v == 0);
    chk("s_hpos",  32'(vga_s.hpos),        32'(h));
    chk("s_vpos",  32'(vga_s.vpos),        32'(v));
    chk("s_tick",  32'(vga_s.pixel_tick),  32'(1));
    chk("s_hsync", 32'(vga_s.hsync),       32'(!hs));
    chk("s_vsync", 32'(vga_s.vsync),       32'(!vs));
    chk("s_act",   32'(vga_s.active),      32'(act));
    chk("s_ls",    32'(vga_s.line_start),  32'(ls));
    chk("s_fs",    32'(vga_s.frame_start), 32'(fs));
    chk("p_hpos",  32'(vga_p.hpos),        32'(h));
    chk("p_vpos",  32'(vga_p.vpos),        32'(v));
    chk("p_hsync", 32'(vga_p.hsync),       32'(hs));
    chk("p_vsync", 32'(vga_p.vsync),       32'(vs));
    chk("p_fs",    32'(vga_p.frame_start), 32'(fs));
  endtask

  task automatic step_small();
    @(posedge clk);
    @(negedge clk);
    ns++;
    chk_small(ns);
  endtask

  // Default timing: c counts enabled clocks since reset release; a pixel lasts two clocks.
  task automatic chk_def(input bit en);
    int h, v;
    bit ls;
    h  = (c / 2) % 800;
    v  = (c / 1600) % 525;
    ls = last_en && (c > 0) && (c % 2 == 0) && (h == 0);
    chk("d_hpos",  32'(vga_d.hpos),        32'(h));
    chk("d_vpos",  32'(vga_d.vpos),        32'(v));
    chk("d_tick",  32'(vga_d.pixel_tick),  32'(en && (c % 2 == 1)));
    chk("d_hsync", 32'(vga_d.hsync),       32'(!(h >= 656 && h <= 751)));
    chk("d_vsync", 32'(vga_d.vsync),       32'(!(v >= 490 && v <= 491)));
    chk("d_act",   32'(vga_d.active),      32'((h < 640) && (v < 480)));
    chk("d_ls",    32'(vga_d.line_start),  32'(ls));
    chk("d_fs",    32'(vga_d.frame_start), 32'(ls && (v == 0)));
  endtask

  task automatic step_def(input bit en);
    vga_d.enable = en;
    @(posedge clk);
    @(negedge clk);
    if (en) c++;
    last_en = en;
    chk_def(en);
  endtask

  initial begin
    rst_d        = 1'b1;
    rst_s        = 1'b1;
    vga_d.enable = 1'b0;
    vga_s.enable = 1'b0;
    vga_p.enable = 1'b0;
    ns           = 0;
    c            = 0;
    last_en      = 1'b0;

    // Small instances: reset state with enable low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("s_rst_hpos",  32'(vga_s.hpos),        32'(0));
    chk("s_rst_vpos",  32'(vga_s.vpos),        32'(0));
    chk("s_rst_act",   32'(vga_s.active),      32'(1));
    chk("s_rst_hsync", 32'(vga_s.hsync),       32'(1));
    chk("s_rst_vsync", 32'(vga_s.vsync),       32'(1));
    chk("s_rst_ls",    32'(vga_s.line_start),  32'(0));
    chk("s_rst_fs",    32'(vga_s.frame_start), 32'(0));
    chk("s_rst_tick",  32'(vga_s.pixel_tick),  32'(0));
    chk("p_rst_hsync", 32'(vga_p.hsync),       32'(0));
    chk("p_rst_vsync", 32'(vga_p.vsync),       32'(0));

    // Run past two frames into (hpos,vpos)=(5,4): both syncs asserted.
    rst_s        = 1'b0;
    vga_s.enable = 1'b1;
    vga_p.enable = 1'b1;
    for (int i = 0; i < 133; i++) step_small();
    chk("s_midsync_h", 32'(vga_s.hsync), 32'(0));
    chk("s_midsync_v", 32'(vga_s.vsync), 32'(0));

    // Reset in the middle of both sync pulses.
    rst_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ns = 0;
    chk_small(0);
    rst_s = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step_small();
      if (ns == 48) begin
        chk("wrap_ls", 32'(vga_s.line_start),  32'(1));
        chk("wrap_fs", 32'(vga_s.frame_start), 32'(1));
      end
    end

    // Default instance: reset state.
    @(negedge clk);
    chk("d_rst_hpos",  32'(vga_d.hpos),        32'(0));
    chk("d_rst_vpos",  32'(vga_d.vpos),        32'(0));
    chk("d_rst_act",   32'(vga_d.active),      32'(1));
    chk("d_rst_hsync", 32'(vga_d.hsync),       32'(1));
    chk("d_rst_vsync", 32'(vga_d.vsync),       32'(1));
    chk("d_rst_ls",    32'(vga_d.line_start),  32'(0));
    chk("d_rst_fs",    32'(vga_d.frame_start), 32'(0));
    chk("d_rst_tick",  32'(vga_d.pixel_tick),  32'(0));

    // Two full lines plus most of a third, up to hpos=639.
    rst_d = 1'b0;
    while (c < 4478) step_def(1'b1);
    chk("d_pre_stall", 32'(vga_d.hpos), 32'(639));

    // Enable stall: everything frozen, no strobes.
    for (int i = 0; i < 7; i++) step_def(1'b0);
    chk("d_stall_hpos", 32'(vga_d.hpos),   32'(639));
    chk("d_stall_act",  32'(vga_d.active), 32'(1));

    // Resume into the front porch.
    for (int i = 0; i < 10; i++) step_def(1'b1);
    chk("d_resume_act", 32'(vga_d.active), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
